// File: rtl/fp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// fp_wb_arbiter : FP regfile write-port arbiter (3 requesters) + busy scoreboard
// Option macro FP_WB_RR_EN: round-robin when defined, else fixed priority.
// Revision: 1.0
// ============================================================================
module fp_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req_valid,
  input  logic [3*ADDR_W-1:0]     req_addr,
  input  logic [3*DATA_W-1:0]     req_data,
  output logic [2:0]              req_ready,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_rd,
  output logic                    issue_stall,
  input  logic [ADDR_W-1:0]       src1_addr,
  input  logic [ADDR_W-1:0]       src2_addr,
  output logic                    src_stall,
  output logic                    fp_reg_we,
  output logic [ADDR_W-1:0]       fp_reg_w_add,
  output logic [DATA_W-1:0]       fp_reg_data,
  output logic [(1<<ADDR_W)-1:0]  busy_vec
);

  localparam int NUM_REG = 1 << ADDR_W;

  logic                grant_any;
  logic [1:0]          grant_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REG-1:0]  busy_nxt;

`ifdef FP_WB_RR_EN
  logic [1:0] last;
  logic [1:0] probe;

  // Search starts one past the last grant and wraps modulo 3.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    probe     = last;
    for (int k = 0; k < 3; k++) begin
      probe = (probe == 2'd2) ? 2'd0 : probe + 2'd1;
      if (!grant_any && req_valid[probe]) begin
        grant_any = 1'b1;
        grant_idx = probe;
      end
    end
    if (!rst) grant_any = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 2'd2;
    end else if (grant_any) begin
      last <= grant_idx;
    end
  end
`else
  always_comb begin
    grant_any = rst && (req_valid != 3'b000);
    if (req_valid[0]) begin
      grant_idx = 2'd0;
    end else if (req_valid[1]) begin
      grant_idx = 2'd1;
    end else begin
      grant_idx = 2'd2;
    end
  end
`endif

  assign req_ready = grant_any ? (3'b001 << grant_idx) : 3'b000;

  always_comb begin
    case (grant_idx)
      2'd1: begin
        sel_addr = req_addr[2*ADDR_W-1:ADDR_W];
        sel_data = req_data[2*DATA_W-1:DATA_W];
      end
      2'd2: begin
        sel_addr = req_addr[3*ADDR_W-1:2*ADDR_W];
        sel_data = req_data[3*DATA_W-1:2*DATA_W];
      end
      default: begin
        sel_addr = req_addr[ADDR_W-1:0];
        sel_data = req_data[DATA_W-1:0];
      end
    endcase
  end

  assign issue_stall = issue_valid & busy_vec[issue_rd];
  assign src_stall   = busy_vec[src1_addr] | busy_vec[src2_addr];

  // Clear is applied first so a same-cycle set on the same register wins.
  always_comb begin
    busy_nxt = busy_vec;
    if (grant_any) busy_nxt[sel_addr] = 1'b0;
    if (issue_valid && !busy_vec[issue_rd]) busy_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_vec     <= '0;
      fp_reg_we    <= 1'b0;
      fp_reg_w_add <= '0;
      fp_reg_data  <= '0;
    end else begin
      busy_vec  <= busy_nxt;
      fp_reg_we <= grant_any;
      if (grant_any) begin
        fp_reg_w_add <= sel_addr;
        fp_reg_data  <= sel_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_wb_arbiter.sv
`default_nettype none
// Testbench for fp_wb_arbiter: vector table, corner sequences, random vs. model.
module tb_fp_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           req_valid;
  logic [3*ADDR_W-1:0]  req_addr;
  logic [3*DATA_W-1:0]  req_data;
  logic [2:0]           req_ready;
  logic                 issue_valid;
  logic [ADDR_W-1:0]    issue_rd;
  logic                 issue_stall;
  logic [ADDR_W-1:0]    src1_addr;
  logic [ADDR_W-1:0]    src2_addr;
  logic                 src_stall;
  logic                 fp_reg_we;
  logic [ADDR_W-1:0]    fp_reg_w_add;
  logic [DATA_W-1:0]    fp_reg_data;
  logic [31:0]          busy_vec;

  always #5 clk = ~clk;

  fp_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .src_stall(src_stall),
    .fp_reg_we(fp_reg_we), .fp_reg_w_add(fp_reg_w_add), .fp_reg_data(fp_reg_data),
    .busy_vec(busy_vec)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit [31:0] m_busy;
  bit        m_we;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  int        m_last;

  logic [4:0]  pa[3];
  logic [31:0] pd[3];

  int          last_g;
  logic [2:0]  seen_ready;
  logic        seen_is;
  logic        seen_ss;

  typedef struct {
    logic [2:0] valid;
    logic       iv;
    logic [4:0] rd;
    logic [4:0] s1;
    logic [4:0] s2;
    logic [2:0] e_rr;
    logic [2:0] e_fx;
    logic       e_is;
    logic       e_ss;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_last = 2;
  endtask

  task automatic drive();
    req_addr = {pa[2], pa[1], pa[0]};
    req_data = {pd[2], pd[1], pd[0]};
  endtask

  function automatic int model_pick();
`ifdef FP_WB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_last + k) % 3;
      if (req_valid[i]) return i;
    end
`else
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    int g;
    bit is_exp;
    #1;
    g = model_pick();
    is_exp = issue_valid && m_busy[issue_rd];
    seen_ready = req_ready;
    seen_is    = issue_stall;
    seen_ss    = src_stall;
    chk("req_ready", 64'(req_ready), 64'((g < 0) ? 0 : (1 << g)));
    chk("issue_stall", 64'(issue_stall), 64'(is_exp));
    chk("src_stall", 64'(src_stall), 64'(m_busy[src1_addr] | m_busy[src2_addr]));
    if (g >= 0) begin
      m_we   = 1'b1;
      m_addr = pa[g];
      m_data = pd[g];
      m_busy[pa[g]] = 1'b0;
      m_last = g;
    end else begin
      m_we = 1'b0;
    end
    if (issue_valid && !is_exp) m_busy[issue_rd] = 1'b1;
    last_g = g;
    @(posedge clk);
    #1;
    chk("fp_reg_we", 64'(fp_reg_we), 64'(m_we));
    chk("fp_reg_w_add", 64'(fp_reg_w_add), 64'(m_addr));
    chk("fp_reg_data", 64'(fp_reg_data), 64'(m_data));
    chk("busy_vec", 64'(busy_vec), 64'(m_busy));
    @(negedge clk);
  endtask

  function automatic logic [2:0] tbl_exp(input vec_t v);
`ifdef FP_WB_RR_EN
    return v.e_rr;
`else
    return v.e_fx;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bb;
    int          waited;
    int          cnt;
    bit          pv[3];

    rst = 1'b1;
    req_valid = 3'b000; issue_valid = 1'b0; issue_rd = '0; src1_addr = '0; src2_addr = '0;
    pa[0] = 5'd10; pa[1] = 5'd11; pa[2] = 5'd12;
    pd[0] = 32'hA000_0000; pd[1] = 32'hB000_0001; pd[2] = 32'hC000_0002;
    drive();
    #2 rst = 1'b0;
    req_valid = 3'b111;

    // Reset state with all requesters valid
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we", 64'(fp_reg_we), 64'd0);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    chk("rst_addr", 64'(fp_reg_w_add), 64'd0);
    chk("rst_data", 64'(fp_reg_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cycle();
    chk("first_grant", 64'(seen_ready), 64'd1);
    chk("first_we", 64'(fp_reg_we), 64'd1);

    // Table vectors start from a fresh reset
    rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    tbl[0] = '{3'b111, 1'b1, 5'd5, 5'd5, 5'd0, 3'b001, 3'b001, 1'b0, 1'b0};
    tbl[1] = '{3'b111, 1'b0, 5'd0, 5'd5, 5'd0, 3'b010, 3'b001, 1'b0, 1'b1};
    tbl[2] = '{3'b111, 1'b1, 5'd5, 5'd0, 5'd0, 3'b100, 3'b001, 1'b1, 1'b0};
    tbl[3] = '{3'b111, 1'b0, 5'd0, 5'd0, 5'd5, 3'b001, 3'b001, 1'b0, 1'b1};
    tbl[4] = '{3'b111, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 3'b001, 1'b0, 1'b0};
    tbl[5] = '{3'b111, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 3'b001, 1'b0, 1'b0};
    tbl[6] = '{3'b000, 1'b0, 5'd0, 5'd6, 5'd7, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[7] = '{3'b110, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 3'b010, 1'b0, 1'b0};
    tbl[8] = '{3'b101, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 3'b001, 1'b0, 1'b0};
    for (int r = 0; r < 9; r++) begin
      req_valid   = tbl[r].valid;
      issue_valid = tbl[r].iv;
      issue_rd    = tbl[r].rd;
      src1_addr   = tbl[r].s1;
      src2_addr   = tbl[r].s2;
      cycle();
      chk($sformatf("tbl%0d_ready", r), 64'(seen_ready), 64'(tbl_exp(tbl[r])));
      chk($sformatf("tbl%0d_istall", r), 64'(seen_is), 64'(tbl[r].e_is));
      chk($sformatf("tbl%0d_sstall", r), 64'(seen_ss), 64'(tbl[r].e_ss));
    end
    issue_valid = 1'b0; src1_addr = '0; src2_addr = '0;

    // Scoreboard clear by FPU write to busy register 5
    req_valid = 3'b010; pa[1] = 5'd5; pd[1] = 32'h3F80_0000; drive();
    src1_addr = 5'd5;
    cycle();
    chk("sb_stall_before", 64'(seen_ss), 64'd1);
    chk("sb_we", 64'(fp_reg_we), 64'd1);
    chk("sb_addr", 64'(fp_reg_w_add), 64'd5);
    chk("sb_data", 64'(fp_reg_data), 64'h3F80_0000);
    chk("sb_busy5", 64'(busy_vec[5]), 64'd0);
    req_valid = 3'b000;
    #1;
    chk("sb_stall_after", 64'(src_stall), 64'd0);
    cycle();
    src1_addr = '0;

    // WAW stall, then same-cycle set and clear on register 9
    issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    bb = busy_vec;
    cycle();
    chk("waw_stall", 64'(seen_is), 64'd1);
    chk("waw_busy_hold", 64'(busy_vec), 64'(bb));
    issue_rd = 5'd9; req_valid = 3'b001; pa[0] = 5'd9; drive();
    cycle();
    chk("set_wins", 64'(busy_vec[9]), 64'd1);
    issue_valid = 1'b0; req_valid = 3'b000;

    // Held load request competing with transfer and FPU
    pa[0] = 5'd20; pa[1] = 5'd21; pa[2] = 5'd3;
    pd[0] = 32'h1111_2222; pd[1] = 32'h3333_4444; pd[2] = 32'hDEAD_BEEF;
    drive();
    req_valid = 3'b111;
    waited = -1; cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (last_g == 2 && waited < 0) waited = k;
      if (last_g >= 0) req_valid[last_g] = 1'b0;
      if (fp_reg_we && fp_reg_w_add == 5'd3 && fp_reg_data == 32'hDEAD_BEEF) cnt++;
    end
    chk("held_wait", 64'(waited >= 0 && waited <= 2), 64'd1);
    chk("held_once", 64'(cnt), 64'd1);

    // Asynchronous reset with busy entries and a write in flight
    issue_valid = 1'b1; issue_rd = 5'd1;
    cycle();
    issue_rd = 5'd2;
    cycle();
    issue_valid = 1'b0;
    pa[0] = 5'd15; pa[1] = 5'd16; drive();
    req_valid = 3'b001;
    cycle();
    chk("mid_busy12", 64'(busy_vec[2:1]), 64'd3);
    chk("mid_we_pending", 64'(fp_reg_we), 64'd1);
    req_valid = 3'b010;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_vec), 64'd0);
    chk("mid_rst_we", 64'(fp_reg_we), 64'd0);
    chk("mid_rst_addr", 64'(fp_reg_w_add), 64'd0);
    chk("mid_rst_data", 64'(fp_reg_data), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_ready2", 64'(req_ready), 64'd0);
    chk("mid_rst_we2", 64'(fp_reg_we), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cycle();
    chk("reset_regrant", 64'(seen_ready), 64'd2);
    req_valid = 3'b000;

    // Random traffic against the model, requests held until granted
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pa[i] = 5'($urandom_range(0, 7));
          pd[i] = $urandom;
        end
      end
      req_valid   = {pv[2], pv[1], pv[0]};
      drive();
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      src1_addr   = 5'($urandom_range(0, 7));
      src2_addr   = 5'($urandom_range(0, 7));
      if (c % 97 == 50) begin
        rst = 1'b0;
        #1;
        chk("rnd_rst_busy", 64'(busy_vec), 64'd0);
        chk("rnd_rst_we", 64'(fp_reg_we), 64'd0);
        rst = 1'b1;
        model_reset();
      end
      cycle();
      if (last_g >= 0) pv[last_g] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
